// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
   typedef logic [4:0] regaddr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } wbarb_state_t;

   localparam regaddr_t REG_X0 = 5'd0;

   // Raw state encodings for the arbiter state register
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between write-back mux, long-latency source, hazard unit and register file.
interface wb_port_arbiter_if #(parameter int XLEN = 32);
   import wb_port_arbiter_pkg::*;

   logic            wb_regwrite;
   regaddr_t        wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            stall_o;
   logic            llu_valid;
   regaddr_t        llu_rd;
   logic [XLEN-1:0] llu_data;
   logic            llu_ready;
   regaddr_t        rs1;
   regaddr_t        rs2;
   logic            rs1_pending;
   logic            rs2_pending;
   logic            rf_we;
   regaddr_t        rf_waddr;
   logic [XLEN-1:0] rf_wdata;

   modport slave (
      input  wb_regwrite, wb_rd, wb_data, llu_valid, llu_rd, llu_data, rs1, rs2,
      output stall_o, llu_ready, rs1_pending, rs2_pending, rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output wb_regwrite, wb_rd, wb_data, llu_valid, llu_rd, llu_data, rs1, rs2,
      input  stall_o, llu_ready, rs1_pending, rs2_pending, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_result_fifo.sv
// Pointer-based sync FIFO for long-latency results; exposes per-entry rd/valid for hazard lookup.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  regaddr_t                    pushRd,
   input  logic [XLEN-1:0]             pushData,
   input  logic                        pop,
   output regaddr_t                    headRd,
   output logic [XLEN-1:0]             headData,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        empty,
   output logic                        full,
   output regaddr_t [DEPTH-1:0]        entRd,
   output logic [DEPTH-1:0]            entVld
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]         wrPtr, rdPtr;
   regaddr_t [DEPTH-1:0]  rdMem;
   logic [XLEN-1:0]       dataMem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rdMem[wrPtr]   <= pushRd;
         dataMem[wrPtr] <= pushData;
      end
   end

   assign headRd   = rdMem[rdPtr];
   assign headData = dataMem[rdPtr];
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign entRd    = rdMem;

   // An entry is live when its distance from the read pointer is below the occupancy
   for (genvar i = 0; i < DEPTH; i++) begin : gVld
      logic [PW-1:0] offs;
      assign offs      = PW'(i) - rdPtr;
      assign entVld[i] = ({1'b0, offs} < count);
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: write-back has priority, queued long-latency
// results retire in order, and a starvation counter forces a one-cycle stall.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   wb_port_arbiter_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]                  state, stateNext;
   logic [3:0]                  age;
   logic                        empty, full, push, pop, bypass, starve, forceSt, wbWrite;
   logic [CW-1:0]               count, countNext;
   regaddr_t                    headRd;
   logic [XLEN-1:0]             headData;
   regaddr_t [FIFO_DEPTH-1:0]   entRd;
   logic [FIFO_DEPTH-1:0]       entVld;
   logic                        grantWe;
   regaddr_t                    grantAddr;
   logic [XLEN-1:0]             grantData;
   logic                        rfWe;
   regaddr_t                    rfWaddr;
   logic [XLEN-1:0]             rfWdata;
   logic                        p1, p2;

   wb_result_fifo #(.XLEN(XLEN), .DEPTH(FIFO_DEPTH)) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pushRd   (bus.llu_rd),
      .pushData (bus.llu_data),
      .pop      (pop),
      .headRd   (headRd),
      .headData (headData),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .entRd    (entRd),
      .entVld   (entVld)
   );

   assign forceSt = (state == ST_FORCE);
   assign wbWrite = bus.wb_regwrite && (bus.wb_rd != REG_X0);
   // Ready comes from registered occupancy only, so a same-cycle pop frees nothing
   assign push    = bus.llu_valid && !full && (bus.llu_rd != REG_X0);

   always_comb begin
      grantWe   = 1'b0;
      grantAddr = bus.wb_rd;
      grantData = bus.wb_data;
      pop       = 1'b0;
      bypass    = 1'b0;
      if (forceSt) begin
         pop       = 1'b1;
         grantWe   = 1'b1;
         grantAddr = headRd;
         grantData = headData;
      end else if (wbWrite) begin
         grantWe = 1'b1;
         bypass  = !empty;
      end else if (!empty) begin
         pop       = 1'b1;
         grantWe   = 1'b1;
         grantAddr = headRd;
         grantData = headData;
      end
   end

   assign starve    = bypass && ((age + 4'd1) == 4'(STARVE_LIMIT));
   assign countNext = count + CW'(push) - CW'(pop);

   always_comb begin
      if (starve)                stateNext = ST_FORCE;
      else if (countNext != '0)  stateNext = ST_WAIT;
      else                       stateNext = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         age     <= '0;
         rfWe    <= 1'b0;
         rfWaddr <= REG_X0;
         rfWdata <= '0;
      end else begin
         state <= stateNext;
         if (pop)         age <= '0;
         else if (bypass) age <= age + 4'd1;
         rfWe <= grantWe;
         if (grantWe) begin
            rfWaddr <= grantAddr;
            rfWdata <= grantData;
         end
      end
   end

   always_comb begin
      p1 = 1'b0;
      p2 = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entVld[i] && (entRd[i] == bus.rs1)) p1 = 1'b1;
         if (entVld[i] && (entRd[i] == bus.rs2)) p2 = 1'b1;
      end
      if (bus.rs1 == REG_X0) p1 = 1'b0;
      if (bus.rs2 == REG_X0) p2 = 1'b0;
   end

   assign bus.stall_o     = forceSt;
   assign bus.llu_ready   = !full;
   assign bus.rs1_pending = p1;
   assign bus.rs2_pending = p2;
   assign bus.rf_we       = rfWe;
   assign bus.rf_waddr    = rfWaddr;
   assign bus.rf_wdata    = rfWdata;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

   wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference model: queued results, bypass count of the current head, forced-stall flag
   ent_t        q[$];
   int          bypassCnt = 0;
   bit          forcing   = 1'b0;
   bit          mWe       = 1'b0;
   logic [4:0]  mAddr     = 5'd0;
   logic [31:0] mData     = 32'd0;

   int nChecks = 0;
   int nFails  = 0;

   logic        obsWe, obsStall, obsReady, obsP1, obsP2;
   logic [4:0]  obsAddr;
   logic [31:0] obsData;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pendingOf(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelStep();
      bit          granted = 1'b0;
      bit          doPop   = 1'b0;
      bit          accept;
      logic [4:0]  gA = 5'd0;
      logic [31:0] gD = 32'd0;
      if (rst) begin
         q.delete();
         bypassCnt = 0;
         forcing   = 1'b0;
         mWe       = 1'b0;
         mAddr     = 5'd0;
         mData     = 32'd0;
         return;
      end
      accept = bus.llu_valid && (q.size() < DEPTH);
      if (forcing) begin
         granted = 1'b1; gA = q[0].rd; gD = q[0].data; doPop = 1'b1;
         forcing = 1'b0;
      end else if (bus.wb_regwrite && bus.wb_rd != 5'd0) begin
         granted = 1'b1; gA = bus.wb_rd; gD = bus.wb_data;
         if (q.size() > 0) begin
            bypassCnt++;
            if (bypassCnt == LIMIT) forcing = 1'b1;
         end
      end else if (q.size() > 0) begin
         granted = 1'b1; gA = q[0].rd; gD = q[0].data; doPop = 1'b1;
      end
      if (doPop) begin
         void'(q.pop_front());
         bypassCnt = 0;
      end
      if (accept && bus.llu_rd != 5'd0) q.push_back('{bus.llu_rd, bus.llu_data});
      mWe = granted;
      if (granted) begin
         mAddr = gA;
         mData = gD;
      end
   endtask

   // One cycle: sample at negedge, compare against model, advance model, return after posedge
   task automatic doCycle();
      @(negedge clk);
      obsWe    = bus.rf_we;
      obsAddr  = bus.rf_waddr;
      obsData  = bus.rf_wdata;
      obsStall = bus.stall_o;
      obsReady = bus.llu_ready;
      obsP1    = bus.rs1_pending;
      obsP2    = bus.rs2_pending;
      check("stall_o", 32'(obsStall), 32'(forcing));
      check("llu_ready", 32'(obsReady), 32'(q.size() < DEPTH));
      check("rs1_pending", 32'(obsP1), 32'(pendingOf(bus.rs1)));
      check("rs2_pending", 32'(obsP2), 32'(pendingOf(bus.rs2)));
      check("rf_we", 32'(obsWe), 32'(mWe));
      if (mWe) begin
         check("rf_waddr", 32'(obsAddr), 32'(mAddr));
         check("rf_wdata", obsData, mData);
      end
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.wb_regwrite = we;  bus.wb_rd  = wrd; bus.wb_data  = wd;
      bus.llu_valid   = lv;  bus.llu_rd = lrd; bus.llu_data = ld;
      bus.rs1 = r1; bus.rs2 = r2;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) doCycle();
   endtask

   int          readyHist[32];
   int          acceptC;
   logic [4:0]  retired[$];

   initial begin
      // Reset with every input active
      rst = 1'b1;
      drive(1, 3, 32'h33, 1, 6, 32'h66, 6, 3);
      repeat (3) begin
         doCycle();
         check("rst_we", 32'(obsWe), 0);
         check("rst_stall", 32'(obsStall), 0);
         check("rst_ready", 32'(obsReady), 1);
      end
      rst = 1'b0;
      idle(1);
      check("post_rst_we", 32'(obsWe), 0);
      check("post_rst_ready", 32'(obsReady), 1);

      // Idle push: pending for one cycle, write two cycles later
      drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
      doCycle();
      drive(0, 0, 0, 0, 0, 0, 5, 0);
      doCycle();
      check("idle_pend", 32'(obsP1), 1);
      doCycle();
      check("idle_pend_gone", 32'(obsP1), 0);
      check("idle_we", 32'(obsWe), 1);
      check("idle_addr", 32'(obsAddr), 5);
      check("idle_data", obsData, 32'hDEADBEEF);
      idle(2);

      // Starvation: x7 queued under continuous x3 write-back
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
      doCycle();
      drive(1, 3, 32'h33, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         doCycle();
         check("starve_nostall", 32'(obsStall), 0);
         check("starve_x3", 32'(obsAddr), 3);
      end
      doCycle();
      check("starve_stall", 32'(obsStall), 1);
      doCycle();
      check("starve_unstall", 32'(obsStall), 0);
      check("starve_x7_addr", 32'(obsAddr), 7);
      check("starve_x7_data", obsData, 32'h77);
      doCycle();
      check("starve_resume_addr", 32'(obsAddr), 3);
      check("starve_resume_data", obsData, 32'h33);
      idle(3);

      // Full FIFO back-pressure with ordered retirement
      acceptC = -1;
      begin
         int k = 0;
         for (int c = 0; c < 24; c++) begin
            drive(1, 3, 32'h33, k < 3, 5'(10 + k), 32'hA0 + 32'(k), 10, 12);
            doCycle();
            readyHist[c] = int'(obsReady);
            if (obsWe && obsAddr != 5'd3) retired.push_back(obsAddr);
            if (k < 3 && obsReady) begin
               if (k == 2) acceptC = c;
               k++;
            end
         end
      end
      check("full_ready_c2", 32'(readyHist[2]), 0);
      check("full_ready_c5", 32'(readyHist[5]), 0);
      check("full_ready_c6", 32'(readyHist[6]), 1);
      check("full_acceptC", 32'(acceptC), 6);
      check("full_retired_n", 32'(retired.size()), 3);
      if (retired.size() == 3) begin
         check("full_order0", 32'(retired[0]), 10);
         check("full_order1", 32'(retired[1]), 11);
         check("full_order2", 32'(retired[2]), 12);
      end
      idle(3);

      // x0 handling
      drive(1, 0, 32'h1, 1, 9, 32'h99, 9, 0);
      doCycle();
      drive(1, 0, 32'h5, 0, 0, 0, 9, 0);
      doCycle();
      check("x0_pend9", 32'(obsP1), 1);
      check("x0_nowrite", 32'(obsWe), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      doCycle();
      check("x0_we", 32'(obsWe), 1);
      check("x0_addr", 32'(obsAddr), 9);
      check("x0_data", obsData, 32'h99);
      drive(0, 0, 0, 1, 0, 32'hBAD, 0, 0);
      doCycle();
      check("x0_llu_ready", 32'(obsReady), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         doCycle();
         check("x0_drop_we", 32'(obsWe), 0);
         check("x0_drop_pend", 32'(obsP1), 0);
      end

      // Reset during a FORCE cycle with two entries queued
      drive(1, 3, 32'h33, 1, 20, 32'h20, 20, 21);
      doCycle();
      drive(1, 3, 32'h33, 1, 21, 32'h21, 20, 21);
      doCycle();
      drive(1, 3, 32'h33, 0, 0, 0, 20, 21);
      repeat (3) doCycle();
      rst = 1'b1;
      doCycle();
      check("mrst_force", 32'(obsStall), 1);
      check("mrst_pend20", 32'(obsP1), 1);
      check("mrst_pend21", 32'(obsP2), 1);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 20, 21);
      doCycle();
      check("mrst_stall", 32'(obsStall), 0);
      check("mrst_ready", 32'(obsReady), 1);
      check("mrst_pend", 32'(obsP1 | obsP2), 0);
      for (int k = 0; k < 4; k++) begin
         doCycle();
         check("mrst_nowrite", 32'(obsWe), 0);
      end

      // Random traffic; write-back inputs held while a stall is expected
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         if (!forcing) begin
            bus.wb_regwrite = ($urandom_range(0, 99) < 70);
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
         end
         bus.llu_valid = ($urandom_range(0, 99) < 45);
         bus.llu_rd    = 5'($urandom_range(0, 7));
         bus.llu_data  = $urandom;
         bus.rs1       = 5'($urandom_range(0, 7));
         bus.rs2       = 5'($urandom_range(0, 7));
         doCycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order write-back stage and a long-latency result source (multiply/divide unit, late load return). The write-back stage has priority. Long-latency results are queued in a small FIFO. A starvation counter forces a one-cycle write-back stall so a queued result always retires. The block sits between the write-back mux output and the register file, and exposes pending-destination lookups to the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 2, long-latency result queue entries; power of two, ≥2
- STARVE_LIMIT, 4, cycles a queued head may be bypassed before a forced stall; 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- wb_regwrite  in  1  write-back stage has a register write this cycle
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data (write-back mux output)
- stall_o  out  1  write-back not consumed this cycle; upstream holds MEM/WB register stable
- llu_valid  in  1  long-latency result offered
- llu_rd  in  5  its destination
- llu_data  in  XLEN  its data
- llu_ready  out  1  result accepted when llu_valid & llu_ready
- rs1, rs2  in  5 each  hazard-unit query registers
- rs1_pending, rs2_pending  out  1 each  a queued entry targets that register (x0 always 0)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  XLEN  write data (registered)

## Operation
- FSM states:
  - IDLE: FIFO empty.
  - WAIT: FIFO non-empty, head age counting.
  - FORCE: stall_o=1, head granted.
- Push: when llu_valid & llu_ready and llu_rd≠0, llu_{rd,data} are enqueued.
  - llu_rd=0 handshakes normally but is discarded.
  - llu_ready = !full, derived from registered occupancy only. A pop in the same cycle does not free the slot until the next cycle.
- Grant, evaluated each cycle:
  - FORCE: the FIFO head writes. The write-back stage is not consumed.
  - Otherwise, wb_regwrite with wb_rd≠0: the write-back stage writes. The head is bypassed and age increments if the FIFO is non-empty.
  - Otherwise, FIFO non-empty: the head writes. This covers wb_regwrite=0 and wb_rd=0. A wb_rd=0 write is consumed with no port use.
- Age counter:
  - Clears on every pop.
  - When a bypass makes age reach STARVE_LIMIT, the next state is FORCE.
  - FORCE lasts exactly one cycle, then goes to WAIT if entries remain, else IDLE.
- Transitions:
  - IDLE→WAIT on push.
  - WAIT→IDLE when the last entry pops with no simultaneous push.
  - A push into an empty FIFO cannot be granted in the same cycle. Minimum long-latency write latency is 2 cycles.
- Pending lookup: combinational compare of rs1/rs2 against all valid FIFO entries.
- Ordering: FIFO entries retire strictly in push order. No reordering against the write-back stage; WAW protection belongs to the hazard unit via *_pending.

## Timing
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - stall_o=0, llu_ready=1
  - *_pending=0, FIFO empty, age=0, state IDLE
- stall_o is decoded from the state register only (state==FORCE). No combinational path from any input.
- rf_* reflect the cycle-N grant at the rising edge ending cycle N (1-cycle latency). rf_we=0 when nothing is granted.
- Stall bound: the write-back stage stalls at most 1 cycle in every STARVE_LIMIT+1 while the FIFO is non-empty.
- Full FIFO with write-back bubbles drains one entry per cycle. llu_ready rises the cycle after the first pop.
- rst asserted mid-operation flushes queued entries (lost by design; the pipeline flushes alongside). If rst is high in a FORCE cycle, stall_o is 0 the next cycle.

## Structure
- Shared package (core package):
  - regaddr_t (logic [4:0])
  - wbarb_state_t enum {IDLE, WAIT, FORCE}
  - REG_X0 constant
- Sub-module: wb_result_fifo, a parameterised sync FIFO.
  - Pointer-based, with an occupancy count.
  - Exposes a per-entry rd/valid vector for the pending compare.
- Arbiter FSM, age counter and output registers live in the top.

## Test plan
- Reset: hold rst 3 cycles with all inputs active → rf_we=0, stall_o=0, llu_ready=1 throughout and on the first cycle after.
- Idle push: llu_valid with rd=5, data=0xDEADBEEF, wb_regwrite=0 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF two cycles later; rs1=5 reads pending for exactly 1 cycle.
- Starvation: enqueue rd=7, hold wb_regwrite=1 (rd=3) continuously, STARVE_LIMIT=4 → 4 writes to x3, then stall_o=1 for one cycle with an x7 write, then x3 resumes with held data unchanged.
- Full / back-pressure: push 3 results back-to-back under continuous write-back traffic, FIFO_DEPTH=2 → llu_ready=0 on cycle 3; the third result is accepted the cycle after the first forced pop; retire order is preserved.
- x0 handling: wb_rd=0 plus a queued head rd=9 → head writes x9 that cycle. llu_rd=0 accepted → never written, never reported pending.
- Mid-operation reset: 2 entries queued and state FORCE, assert rst → FIFO empty, stall_o=0, no later writes of flushed entries.
